ibex_regfile_wb_stage: RTL and testbench
========================================

Name: ibex_regfile_wb_stage

Overview:
- Writeback stage directly upstream of the flop-based register file's write port (waddr/wdata/we).
- Accepts one retiring instruction per handshake from EX: either an ALU result, or a load that waits for the LSU response.
- Drives the register file write port, including the dummy-instruction marker.
- Suppresses writes to R0, drops faulted load writes and flags LSU protocol errors.

Parameters:
- DataWidth, 32, width of the write data path.
- DummyInstructions, 0, when 1, a dummy instruction targeting R0 writes the real R0 register; when 0, R0 writes are always suppressed.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- ex_valid_i  in  1  EX presents a retiring instruction
- ex_ready_o  out  1  stage accepts the instruction this cycle
- ex_rd_addr_i  in  5  destination register
- ex_rd_we_i  in  1  instruction writes rd
- ex_is_load_i  in  1  result comes from the LSU, not from ex_wdata_i
- ex_wdata_i  in  DataWidth  ALU/CSR result (ignored for loads)
- ex_dummy_i  in  1  instruction is a dummy instruction
- lsu_resp_valid_i  in  1  load response strobe
- lsu_resp_rdata_i  in  DataWidth  load data
- lsu_resp_err_i  in  1  load faulted
- rf_waddr_o  out  5  register file write address
- rf_wdata_o  out  DataWidth  register file write data
- rf_we_o  out  1  register file write enable
- rf_dummy_wb_o  out  1  write belongs to a dummy instruction
- wb_busy_o  out  1  stage holds an instruction (state != IDLE)
- err_o  out  1  one-cycle pulse: faulted load or unexpected LSU response

Behaviour:
- Clock is clk_i. Reset is rst_i: synchronous, active-high. All state regs clear on a clk_i edge with rst_i=1.
- After reset: state=IDLE; captured fields 0; rf_we_o=0; rf_waddr_o=0; rf_wdata_o=0; rf_dummy_wb_o=0; wb_busy_o=0; err_o=0.
- FSM states: IDLE, COMMIT, WAIT_LSU.
- Accept: ex_valid_i && ex_ready_o. Captures rd_addr, rd_we, is_load, wdata and dummy into registers.
- Next state on accept: WAIT_LSU if is_load, else COMMIT. With no accept: COMMIT->IDLE, IDLE->IDLE.
- ex_ready_o = (state==IDLE) || (state==COMMIT) || (state==WAIT_LSU && lsu_resp_valid_i). This gives back-to-back ALU throughput of 1/cycle.
- WAIT_LSU without lsu_resp_valid_i: hold, ex_ready_o=0. An unbounded wait is legal.
- Write qualifier: wr_ok = rd_we && (rd_addr!=0 || (DummyInstructions && dummy)).
- COMMIT: rf_we_o = wr_ok; rf_wdata_o = captured wdata; rf_waddr_o = rd_addr. Latency is 1 cycle from accept to write.
- WAIT_LSU with lsu_resp_valid_i: the write happens the same cycle, combinationally from the response.
  - rf_wdata_o = lsu_resp_rdata_i.
  - rf_we_o = wr_ok && !lsu_resp_err_i.
  - Then the FSM goes to IDLE, or to COMMIT/WAIT_LSU if a new instruction is accepted in that cycle.
- rf_dummy_wb_o = captured dummy whenever state != IDLE.
- In IDLE: rf_we_o=0; rf_waddr_o and rf_wdata_o hold their last values (don't-care).
- err_o is registered and pulses the cycle after either event:
  - WAIT_LSU response with lsu_resp_err_i=1;
  - lsu_resp_valid_i while state != WAIT_LSU (spurious response). A spurious response is otherwise ignored, with no write and no state change.
- Reset asserted mid-WAIT_LSU: state goes to IDLE and the pending load is discarded. A response arriving after reset counts as spurious and raises err_o.
- When ex_valid_i=0 in an accept-capable state, no capture occurs.

Optional Feature:
- Macro: IBEX_RF_WB_FWD_EN.
- Defined: adds outputs fwd_valid_o (1), fwd_addr_o (5) and fwd_wdata_o (DataWidth).
  - fwd_valid_o = rf_we_o. Address and data equal rf_waddr_o and rf_wdata_o.
  - ID uses these to bypass the register file for a same-cycle read-after-write.
  - Forwarding of dummy writes is blocked: fwd_valid_o = rf_we_o && !rf_dummy_wb_o.
- Undefined: these ports do not exist; no other behaviour changes.

Test Plan:
- Reset with rst_i=1 for 2 cycles, then ex_valid_i=0 -> all outputs 0, wb_busy_o=0, ex_ready_o=1.
- ALU instrs back-to-back: rd=5 wdata=0xDEADBEEF, then rd=6 wdata=0x12345678 -> rf_we_o=1 in cycles 1 and 2 with matching addr/data; ex_ready_o stays 1.
- ALU write to rd=0, we=1 -> rf_we_o=0. Same with ex_dummy_i=1 and DummyInstructions=1 -> rf_we_o=1, rf_dummy_wb_o=1.
- Load to rd=10, response after 3 cycles with rdata=0xCAFEF00D -> ex_ready_o=0 for 3 cycles; on the response cycle rf_we_o=1, rf_wdata_o=0xCAFEF00D; a new instruction is accepted in the same cycle.
- Load to rd=11 with response lsu_resp_err_i=1 -> rf_we_o=0; err_o=1 exactly one cycle later.
- lsu_resp_valid_i in IDLE -> no write, err_o pulse next cycle. Reset during WAIT_LSU -> IDLE, no write.

Source files
------------

// File: rtl/ibex_regfile_wb_stage.sv
// Writeback stage feeding the register file write port; ALU results commit, loads wait for the LSU.
// Latency: ALU write 1 cycle after accept; load write in the same cycle as its LSU response.
// Backpressure: ex_ready_o drops only while a load waits for its response. Optional macro IBEX_RF_WB_FWD_EN adds a bypass port.
module ibex_regfile_wb_stage #(
   parameter int unsigned DataWidth         = 32,
   parameter bit          DummyInstructions = 1'b0
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 ex_valid_i,
   output logic                 ex_ready_o,
   input  logic [4:0]           ex_rd_addr_i,
   input  logic                 ex_rd_we_i,
   input  logic                 ex_is_load_i,
   input  logic [DataWidth-1:0] ex_wdata_i,
   input  logic                 ex_dummy_i,
   input  logic                 lsu_resp_valid_i,
   input  logic [DataWidth-1:0] lsu_resp_rdata_i,
   input  logic                 lsu_resp_err_i,
   output logic [4:0]           rf_waddr_o,
   output logic [DataWidth-1:0] rf_wdata_o,
   output logic                 rf_we_o,
   output logic                 rf_dummy_wb_o,
   output logic                 wb_busy_o,
`ifdef IBEX_RF_WB_FWD_EN
   output logic                 fwd_valid_o,
   output logic [4:0]           fwd_addr_o,
   output logic [DataWidth-1:0] fwd_wdata_o,
`endif
   output logic                 err_o
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      COMMIT   = 2'd1,
      WAIT_LSU = 2'd2
   } state_e;

   state_e               state;
   // The load/ALU distinction lives in the state itself, so is_load needs no separate flop.
   logic [4:0]           rd_addr;
   logic                 rd_we;
   logic [DataWidth-1:0] wdata;
   logic                 dummy;

   logic accept;
   logic resp_ok;
   logic wr_ok;

   // Accept whenever the stage is empty, committing, or retiring its load this cycle.
   assign ex_ready_o = (state == IDLE) || (state == COMMIT) ||
                       ((state == WAIT_LSU) && lsu_resp_valid_i);
   assign accept     = ex_valid_i && ex_ready_o;
   assign resp_ok    = (state == WAIT_LSU) && lsu_resp_valid_i;
   // R0 is writable only by dummy instructions, and only when that feature is built in.
   assign wr_ok      = rd_we && ((rd_addr != 5'd0) || (DummyInstructions && dummy));
   assign wb_busy_o  = (state != IDLE);

   // FSM, field capture and registered error pulse.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= IDLE;
         rd_addr <= 5'd0;
         rd_we   <= 1'b0;
         wdata   <= '0;
         dummy   <= 1'b0;
         err_o   <= 1'b0;
      end else begin
         // Faulted load, or a response that arrives with no load outstanding.
         err_o <= lsu_resp_valid_i && ((state != WAIT_LSU) || lsu_resp_err_i);
         if (accept) begin
            rd_addr <= ex_rd_addr_i;
            rd_we   <= ex_rd_we_i;
            wdata   <= ex_wdata_i;
            dummy   <= ex_dummy_i;
            state   <= ex_is_load_i ? WAIT_LSU : COMMIT;
         end else if ((state == COMMIT) || resp_ok) begin
            state <= IDLE;
         end
      end
   end

   // Register file write port: captured ALU data in COMMIT, live LSU data on a load response.
   always_comb begin
      rf_waddr_o    = rd_addr;
      rf_wdata_o    = wdata;
      rf_we_o       = 1'b0;
      rf_dummy_wb_o = 1'b0;
      case (state)
         COMMIT: begin
            rf_we_o       = wr_ok;
            rf_dummy_wb_o = dummy;
         end
         WAIT_LSU: begin
            rf_wdata_o    = lsu_resp_rdata_i;
            rf_we_o       = resp_ok && wr_ok && !lsu_resp_err_i;
            rf_dummy_wb_o = dummy;
         end
         default: ;
      endcase
   end

`ifdef IBEX_RF_WB_FWD_EN
   // Dummy writes must never be visible to ID through the bypass.
   assign fwd_valid_o = rf_we_o && !rf_dummy_wb_o;
   assign fwd_addr_o  = rf_waddr_o;
   assign fwd_wdata_o = rf_wdata_o;
`endif

endmodule

// File: tb/tb_ibex_regfile_wb_stage.sv
// Directed bench for ibex_regfile_wb_stage built with DummyInstructions=1.
// Inputs change just after the falling edge; outputs are checked 1 time unit later.
// Registered err_o is checked in the cycle after the triggering event.
module tb_ibex_regfile_wb_stage;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        ex_valid_i;
   logic        ex_ready_o;
   logic [4:0]  ex_rd_addr_i;
   logic        ex_rd_we_i;
   logic        ex_is_load_i;
   logic [31:0] ex_wdata_i;
   logic        ex_dummy_i;
   logic        lsu_resp_valid_i;
   logic [31:0] lsu_resp_rdata_i;
   logic        lsu_resp_err_i;
   logic [4:0]  rf_waddr_o;
   logic [31:0] rf_wdata_o;
   logic        rf_we_o;
   logic        rf_dummy_wb_o;
   logic        wb_busy_o;
   logic        err_o;
`ifdef IBEX_RF_WB_FWD_EN
   logic        fwd_valid_o;
   logic [4:0]  fwd_addr_o;
   logic [31:0] fwd_wdata_o;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   ibex_regfile_wb_stage #(
      .DataWidth         (32),
      .DummyInstructions (1'b1)
   ) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .ex_valid_i       (ex_valid_i),
      .ex_ready_o       (ex_ready_o),
      .ex_rd_addr_i     (ex_rd_addr_i),
      .ex_rd_we_i       (ex_rd_we_i),
      .ex_is_load_i     (ex_is_load_i),
      .ex_wdata_i       (ex_wdata_i),
      .ex_dummy_i       (ex_dummy_i),
      .lsu_resp_valid_i (lsu_resp_valid_i),
      .lsu_resp_rdata_i (lsu_resp_rdata_i),
      .lsu_resp_err_i   (lsu_resp_err_i),
      .rf_waddr_o       (rf_waddr_o),
      .rf_wdata_o       (rf_wdata_o),
      .rf_we_o          (rf_we_o),
      .rf_dummy_wb_o    (rf_dummy_wb_o),
      .wb_busy_o        (wb_busy_o),
`ifdef IBEX_RF_WB_FWD_EN
      .fwd_valid_o      (fwd_valid_o),
      .fwd_addr_o       (fwd_addr_o),
      .fwd_wdata_o      (fwd_wdata_o),
`endif
      .err_o            (err_o)
   );

   initial forever #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Wait for the falling edge, apply one cycle of stimulus, then let combinational outputs settle.
   task automatic drive(input logic rst, input logic vld, input logic [4:0] rd, input logic we,
                        input logic ld, input logic [31:0] wd, input logic dmy,
                        input logic rv, input logic [31:0] rdata, input logic rerr);
      @(negedge clk_i);
      rst_i            = rst;
      ex_valid_i       = vld;
      ex_rd_addr_i     = rd;
      ex_rd_we_i       = we;
      ex_is_load_i     = ld;
      ex_wdata_i       = wd;
      ex_dummy_i       = dmy;
      lsu_resp_valid_i = rv;
      lsu_resp_rdata_i = rdata;
      lsu_resp_err_i   = rerr;
      #1;
   endtask

   task automatic idle(input logic rst);
      drive(rst, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
   endtask

   initial begin
      rst_i = 1'b1; ex_valid_i = 1'b0; ex_rd_addr_i = '0; ex_rd_we_i = 1'b0;
      ex_is_load_i = 1'b0; ex_wdata_i = '0; ex_dummy_i = 1'b0;
      lsu_resp_valid_i = 1'b0; lsu_resp_rdata_i = '0; lsu_resp_err_i = 1'b0;

      // Reset for two edges, then idle.
      idle(1'b1);
      idle(1'b1);
      idle(1'b0);
      check("rst_we",    rf_we_o,       0);
      check("rst_waddr", rf_waddr_o,    0);
      check("rst_wdata", rf_wdata_o,    0);
      check("rst_dummy", rf_dummy_wb_o, 0);
      check("rst_busy",  wb_busy_o,     0);
      check("rst_err",   err_o,         0);
      check("rst_ready", ex_ready_o,    1);

      // Back-to-back ALU instructions.
      drive(1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 1'b0);
      check("alu0_ready", ex_ready_o, 1);
      drive(1'b0, 1'b1, 5'd6, 1'b1, 1'b0, 32'h12345678, 1'b0, 1'b0, 32'h0, 1'b0);
      check("alu1_we",    rf_we_o,    1);
      check("alu1_waddr", rf_waddr_o, 5);
      check("alu1_wdata", rf_wdata_o, 32'hDEADBEEF);
      check("alu1_ready", ex_ready_o, 1);
      check("alu1_busy",  wb_busy_o,  1);
`ifdef IBEX_RF_WB_FWD_EN
      check("alu1_fwd_vld", fwd_valid_o, 1);
      check("alu1_fwd_dat", fwd_wdata_o, 32'hDEADBEEF);
`endif
      idle(1'b0);
      check("alu2_we",    rf_we_o,    1);
      check("alu2_waddr", rf_waddr_o, 6);
      check("alu2_wdata", rf_wdata_o, 32'h12345678);
      idle(1'b0);
      check("alu_idle_we",   rf_we_o,   0);
      check("alu_idle_busy", wb_busy_o, 0);

      // R0: suppressed for a normal instruction, written by a dummy one.
      drive(1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 32'h00001111, 1'b0, 1'b0, 32'h0, 1'b0);
      drive(1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 32'h00002222, 1'b1, 1'b0, 32'h0, 1'b0);
      check("r0_we",    rf_we_o,       0);
      check("r0_dummy", rf_dummy_wb_o, 0);
      idle(1'b0);
      check("r0d_we",    rf_we_o,       1);
      check("r0d_waddr", rf_waddr_o,    0);
      check("r0d_wdata", rf_wdata_o,    32'h00002222);
      check("r0d_dummy", rf_dummy_wb_o, 1);
`ifdef IBEX_RF_WB_FWD_EN
      check("r0d_fwd_blocked", fwd_valid_o, 0);
`endif

      // Load to r10, response three cycles later, next instruction accepted alongside it.
      drive(1'b0, 1'b1, 5'd10, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      check("ld_idle_dummy", rf_dummy_wb_o, 0);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 32'h00000077, 1'b0, 1'b0, 32'h0, 1'b0);
         check($sformatf("ld_wait%0d_ready", i), ex_ready_o, 0);
         check($sformatf("ld_wait%0d_we", i),    rf_we_o,    0);
         check($sformatf("ld_wait%0d_busy", i),  wb_busy_o,  1);
      end
      drive(1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 32'h00000077, 1'b0, 1'b1, 32'hCAFEF00D, 1'b0);
      check("ld_resp_ready", ex_ready_o, 1);
      check("ld_resp_we",    rf_we_o,    1);
      check("ld_resp_waddr", rf_waddr_o, 10);
      check("ld_resp_wdata", rf_wdata_o, 32'hCAFEF00D);
      idle(1'b0);
      check("ld_next_we",    rf_we_o,    1);
      check("ld_next_waddr", rf_waddr_o, 7);
      check("ld_next_wdata", rf_wdata_o, 32'h00000077);
      check("ld_next_err",   err_o,      0);

      // Faulted load to r11.
      drive(1'b0, 1'b1, 5'd11, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h00005555, 1'b1);
      check("lderr_we",    rf_we_o,    0);
      check("lderr_err0",  err_o,      0);
      check("lderr_ready", ex_ready_o, 1);
      idle(1'b0);
      check("lderr_err1", err_o,     1);
      check("lderr_busy", wb_busy_o, 0);
      idle(1'b0);
      check("lderr_err2", err_o, 0);

      // Spurious response while idle.
      drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h00006666, 1'b0);
      check("spur_we",   rf_we_o, 0);
      check("spur_err0", err_o,   0);
      idle(1'b0);
      check("spur_err1", err_o,     1);
      check("spur_busy", wb_busy_o, 0);
      idle(1'b0);
      check("spur_err2", err_o, 0);

      // Reset while a load is outstanding; the late response is spurious.
      drive(1'b0, 1'b1, 5'd12, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      idle(1'b1);
      check("rstld_busy0", wb_busy_o, 1);
      drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h00009999, 1'b0);
      check("rstld_busy1", wb_busy_o,  0);
      check("rstld_we",    rf_we_o,    0);
      check("rstld_ready", ex_ready_o, 1);
      idle(1'b0);
      check("rstld_err", err_o, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
